// File: rtl/ram_pkg.sv
// Shared refresh constants for the DRAM controller and its refresh scheduler.
package ram_pkg;

    localparam int unsigned REF_PERIOD     = 250;
    localparam int unsigned REF_DEBT_W     = 3;
    localparam int unsigned REF_URG_THRESH = 2;
    localparam int unsigned REF_URG_WINDOW = 32;
    localparam int unsigned REF_GAP        = 3;

    // CLK cycles per refresh interval, rounded to nearest (16000 kHz, 15600 ns -> 250).
    function automatic int unsigned ref_period(input int unsigned clk_khz,
                                               input int unsigned interval_ns);
        return (clk_khz * interval_ns + 32'd500_000) / 32'd1_000_000;
    endfunction

endpackage

// File: rtl/ref_interval_timer.sv
// Refresh interval down-counter: reloads PERIOD-1 at zero, holds while disabled.
module ref_interval_timer
    import ram_pkg::*;
#(
    parameter int unsigned PERIOD = REF_PERIOD,
    parameter int unsigned CNT_W  = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    output logic [CNT_W-1:0] count_next,
    output logic             tick
);

    logic [CNT_W-1:0] count;

    always_comb begin
        tick       = en && (count == '0);
        count_next = count;
        if (tick)
            count_next = CNT_W'(PERIOD - 1);
        else if (en)
            count_next = count - CNT_W'(1);
    end

    always_ff @(posedge clk) begin
        if (rst)
            count <= CNT_W'(PERIOD - 1);
        else
            count <= count_next;
    end

endmodule

// File: rtl/ram_refresh_sched.sv
// Refresh request generator: tracks owed refreshes and drives RefReq/RefUrg,
// with a forced low gap after every acknowledged refresh.
module ram_refresh_sched
    import ram_pkg::*;
#(
    parameter int unsigned PERIOD     = REF_PERIOD,
    parameter int unsigned CNT_W      = 8,
    parameter int unsigned DEBT_W     = REF_DEBT_W,
    parameter int unsigned URG_THRESH = REF_URG_THRESH,
    parameter int unsigned URG_WINDOW = REF_URG_WINDOW,
    parameter int unsigned GAP        = REF_GAP
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              En,
    input  logic              RefAck,
    output logic              RefReq,
    output logic              RefUrg,
    output logic [DEBT_W-1:0] Debt,
    output logic              Overflow
);

    localparam int unsigned GAP_W = $clog2(GAP + 1);
    localparam logic [DEBT_W-1:0] DEBT_MAX = '1;

    logic             tick;
    logic [CNT_W-1:0] timer_next;
    logic [DEBT_W-1:0] debt_next;
    logic [GAP_W-1:0] gap, gap_next;
    logic             ovf_next, req_next, urg_next;

    ref_interval_timer #(
        .PERIOD (PERIOD),
        .CNT_W  (CNT_W)
    ) u_timer (
        .clk        (CLK),
        .rst        (RST),
        .en         (En),
        .count_next (timer_next),
        .tick       (tick)
    );

    always_comb begin
        debt_next = Debt;
        ovf_next  = Overflow;
        if (tick && !RefAck) begin
            if (Debt == DEBT_MAX)
                ovf_next = 1'b1;
            else
                debt_next = Debt + DEBT_W'(1);
        end else if (RefAck && !tick && (Debt != '0)) begin
            debt_next = Debt - DEBT_W'(1);
        end

        gap_next = gap;
        if (RefAck)
            gap_next = GAP_W'(GAP);
        else if (gap != '0)
            gap_next = gap - GAP_W'(1);

        // Outputs registered from next-state so RefReq rises with the debt itself.
        req_next = (gap_next == '0) && (debt_next != '0);
        urg_next = req_next && ((debt_next >= DEBT_W'(URG_THRESH)) ||
                                (timer_next < CNT_W'(URG_WINDOW)));
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            Debt     <= '0;
            gap      <= '0;
            RefReq   <= 1'b0;
            RefUrg   <= 1'b0;
            Overflow <= 1'b0;
        end else begin
            Debt     <= debt_next;
            gap      <= gap_next;
            RefReq   <= req_next;
            RefUrg   <= urg_next;
            Overflow <= ovf_next;
        end
    end

endmodule

// File: doc/ram_refresh_sched.md
Name: ram_refresh_sched

Overview:
- Upstream companion of the DRAM controller; generates the controller's RefReqIn / RefUrgIn pair.
- Counts CLK cycles per DRAM refresh interval and tracks owed refreshes in a saturating debt counter.
- RefReq stays up while any refresh is owed. RefUrg escalates when debt piles up or the next interval deadline is near.
- After each completed refresh, both requests drop for a guaranteed gap, so the controller's edge-based "refresh done" latch re-arms.

Parameters:
PERIOD, 250, CLK cycles per refresh interval (15.6 us at 16 MHz); must be >= URG_WINDOW+2
CNT_W, 8, width of interval timer; 2^CNT_W >= PERIOD
DEBT_W, 3, width of debt counter; max debt = 2^DEBT_W-1
URG_THRESH, 2, debt level at or above which RefUrg asserts unconditionally; 1 <= URG_THRESH <= 2^DEBT_W-1
URG_WINDOW, 32, RefUrg also asserts when debt>0 and timer < URG_WINDOW
GAP, 3, cycles both outputs are forced low after each RefAck; >= 2 (covers controller's 2-flop sync)

Ports:
CLK  in  1  system clock, all logic on rising edge
RST  in  1  synchronous, active-high reset
En  in  1  1 = interval timer runs; 0 = timer holds, no new debt
RefAck  in  1  one-cycle pulse from controller when a refresh RAS cycle is started
RefReq  out  1  non-urgent refresh request (registered)
RefUrg  out  1  urgent refresh request (registered)
Debt  out  DEBT_W  current owed-refresh count (debug)
Overflow  out  1  sticky: an interval elapsed while debt was saturated

Behaviour:
- Reset (RST=1 at edge): timer=PERIOD-1, debt=0, gap=0, RefReq=0, RefUrg=0, Overflow=0. RST overrides all other inputs, including mid-gap and mid-request.
- Timer: when En=1, decrements each cycle. At 0 it reloads PERIOD-1 and raises internal tick for that cycle. With En=0, timer holds and tick=0.
- Debt update, per edge:
  - tick & !ack: debt+1, saturating at 2^DEBT_W-1. A tick at saturation sets Overflow; debt stays saturated.
  - ack & !tick: debt-1 if debt>0. Ack at debt 0 is ignored: no underflow, no flag.
  - tick & ack: debt unchanged, except a saturated debt stays saturated and Overflow is not set.
- Gap counter: RefAck loads gap=GAP; otherwise it decrements toward 0. Reload happens even if gap is nonzero.
- Output registers are computed from next-state values, so RefReq rises on the same edge debt becomes nonzero.
  - RefReq_next = (gap_next==0) & (debt_next>0)
  - RefUrg_next = RefReq_next & (debt_next>=URG_THRESH | timer_next<URG_WINDOW)
- RefUrg implies RefReq at all times.
- Latency:
  - RefAck drops RefReq/RefUrg on the following edge.
  - Outputs stay low exactly GAP cycles, then reassert on the next edge if debt is still >0.
- Overflow clears only on RST.
- No combinational path from inputs to outputs.

Decomposition:
- Shared package ram_pkg holds:
  - default constants: REF_PERIOD=250, REF_DEBT_W=3, REF_URG_THRESH=2, REF_URG_WINDOW=32, REF_GAP=3
  - the refresh-period derivation from CLK frequency, so the controller and this block agree
- One natural sub-module: ref_interval_timer, the down-counter with reload, En hold and tick output.
- Debt, gap and output logic stay in the top.

Test Plan:
- Reset, En=1, no ack: first tick at cycle 250 → debt=1, RefReq=1, RefUrg=0. At cycle 250+(250-32)=468, timer<32 → RefUrg=1.
- Ack one cycle after RefReq rises with debt=1 → debt=0, RefReq=RefUrg=0 next edge, and they stay 0 until the next tick.
- Let 2 ticks elapse with no ack → debt=2, RefUrg=1 immediately. Ack once → outputs low exactly 3 cycles, then RefReq=1 and RefUrg=0 (if timer>=32).
- Withhold ack for 8 intervals → debt saturates at 7 after 7 ticks, Overflow=1 on the 8th tick, debt stays 7. Assert RST mid-interval → all outputs 0, timer reloads to 249.
- Force tick and ack in the same cycle at debt=3 → debt stays 3, gap loads 3, RefReq low 3 cycles. Ack with debt=0 → debt stays 0, Overflow stays 0.
- En=0 for 1000 cycles → no ticks, debt unchanged, acks still decrement. Re-enable → the tick arrives after the held remaining count, not after a fresh 250.
